step_tick_scheduler: RTL

- Run-controlled, programmable clock-enable generator for the LFSR datapath. Replaces free-running divided clocks with single-cycle step enables in the `clk` domain.
- Software or a test sequencer loads a divide ratio and a step count, then starts a run. The block issues exactly that many step enables, evenly spaced, and reports completion.
- Sits between the configuration/control logic and any stepped datapath (LFSR shift, sampling), which stays on `clk` gated by `step_en`.

---
 rtl/step_tick_scheduler.sv | 114 +++++++++++
 1 files changed

// File: rtl/step_tick_scheduler.sv
// Run-controlled clock-enable generator: issues a programmed number of evenly
// spaced single-cycle step enables in the clk domain and flags completion.
module step_tick_scheduler #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_steps,
    input  logic             start,
    input  logic             abort,
    output logic             step_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_steps;
    logic [CNT_W-1:0] r_steps_done;
    logic             r_step_en;
    logic             r_done;

    logic             w_cfg_acc;
    logic             w_start;
    logic             w_step;
    logic             w_done;
    logic             w_tick;
    logic             w_finish;

    always_comb begin
        w_state_nxt = r_state;
        w_cfg_acc   = 1'b0;
        w_start     = 1'b0;
        w_step      = 1'b0;
        w_done      = 1'b0;
        w_tick      = (r_cnt == r_div - DIV_W'(1));
        // Final step is visible on step_en; completion takes effect one edge later.
        w_finish    = (r_steps != '0) && r_step_en && (r_steps_done == r_steps);
        case (r_state)
            S_IDLE: begin
                w_cfg_acc = cfg_valid;
                if (start) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_finish) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_step = w_tick;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div        <= DIV_W'(1);
            r_steps      <= CNT_W'(1);
            r_cnt        <= '0;
            r_steps_done <= '0;
            r_step_en    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_step_en <= w_step;
            r_done    <= w_done;
            if (w_cfg_acc) begin
                r_div   <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
                r_steps <= cfg_steps;
            end
            if (w_start) begin
                r_cnt        <= '0;
                r_steps_done <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
                if (w_step && (r_steps_done != '1)) begin
                    r_steps_done <= r_steps_done + CNT_W'(1);
                end
            end
        end
    end

    assign busy       = (r_state == S_RUN);
    assign cfg_ready  = (r_state == S_IDLE);
    assign step_en    = r_step_en;
    assign done       = r_done;
    assign steps_done = r_steps_done;

endmodule
